// File: rtl/smallseg_g0_update_writer_if.sv
// Command / table-write / response bundle between the update controller,
// the G0 write engine and the table's write port.
interface smallseg_g0_update_writer_if #(
   parameter int INDEX_BIT_LEN    = 11,
   parameter int ENTRY_DATA_WIDTH = 98,
   parameter int COMMAND_BIT_LEN  = 2
);
   logic                        cmd_valid;
   logic                        cmd_ready;
   logic [COMMAND_BIT_LEN-1:0]  cmd_op;
   logic [31:0]                 cmd_srcIP;
   logic [31:0]                 cmd_dstIP;
   logic [INDEX_BIT_LEN-1:0]    cmd_ruleID;
   logic [INDEX_BIT_LEN-1:0]    cmd_link;
   logic [INDEX_BIT_LEN-1:0]    cmd_index;
   logic                        tbl_we;
   logic [INDEX_BIT_LEN-1:0]    tbl_index;
   logic [ENTRY_DATA_WIDTH-1:0] tbl_din;
   logic                        rsp_valid;
   logic                        rsp_ready;
   logic [INDEX_BIT_LEN-1:0]    rsp_index;
   logic                        rsp_err;
   logic [INDEX_BIT_LEN:0]      free_count;

   // Controller side: issues commands, consumes responses, observes the write port.
   modport master (
      output cmd_valid, cmd_op, cmd_srcIP, cmd_dstIP, cmd_ruleID, cmd_link, cmd_index, rsp_ready,
      input  cmd_ready, tbl_we, tbl_index, tbl_din, rsp_valid, rsp_index, rsp_err, free_count
   );

   // Writer side.
   modport slave (
      input  cmd_valid, cmd_op, cmd_srcIP, cmd_dstIP, cmd_ruleID, cmd_link, cmd_index, rsp_ready,
      output cmd_ready, tbl_we, tbl_index, tbl_din, rsp_valid, rsp_index, rsp_err, free_count
   );
endinterface

// File: rtl/smallseg_g0_update_writer.sv
// Write-side engine for one small-segment/G0 table: accepts insert/delete
// commands, allocates slots (recycled LIFO first, then a bump pointer),
// issues one-cycle table writes and returns the slot index or an error.
module smallseg_g0_update_writer #(
   parameter int TABLE_ENTRY_SIZE = 1738,
   parameter int INDEX_BIT_LEN    = 11,
   parameter int ENTRY_DATA_WIDTH = 98,
   parameter int COMMAND_BIT_LEN  = 2,
   parameter int FREE_DEPTH       = 64
) (
   input logic                        clk,
   input logic                        rst,
   smallseg_g0_update_writer_if.slave bus
);
   localparam int IW  = INDEX_BIT_LEN;
   localparam int SPW = $clog2(FREE_DEPTH + 1);
   localparam int SAW = $clog2(FREE_DEPTH);
   localparam logic [IW:0]  LAST_IDX = (IW+1)'(TABLE_ENTRY_SIZE);
   localparam logic [IW:0]  BUMP_END = (IW+1)'(TABLE_ENTRY_SIZE + 1);
   localparam logic [SPW-1:0] SP_FULL = SPW'(FREE_DEPTH);
   localparam logic [COMMAND_BIT_LEN-1:0] OP_INSERT = COMMAND_BIT_LEN'(1);
   localparam logic [COMMAND_BIT_LEN-1:0] OP_DELETE = COMMAND_BIT_LEN'(2);

   typedef enum logic [1:0] {S_IDLE, S_ALLOC, S_WRITE, S_RESP} state_t;

   state_t                    state_reg, state_next;
   logic                      is_del_reg;
   logic                      err_reg;
   logic [IW-1:0]             idx_reg;
   logic [31:0]               src_reg;
   logic [31:0]               dst_reg;
   logic [IW-1:0]             rule_reg;
   logic [IW-1:0]             link_reg;
   logic [IW:0]               bump_reg;
   logic [SPW-1:0]            sp_reg;
   logic [IW-1:0]             stack_mem [FREE_DEPTH];

   logic                      pool_empty;
   logic                      del_bad;
   logic                      write_fire;
   logic [SAW-1:0]            pop_addr;
   logic [SAW-1:0]            push_addr;
   logic [ENTRY_DATA_WIDTH-1:0] entry_data;

   assign pool_empty = (sp_reg == '0) && (bump_reg == BUMP_END);
   // The stack cannot change between acceptance and WRITE, so the delete
   // error (including stack-full) is decided when the command is latched.
   assign del_bad    = (bus.cmd_index == '0) || ({1'b0, bus.cmd_index} > LAST_IDX) || (sp_reg == SP_FULL);
   assign write_fire = (state_reg == S_WRITE) && !err_reg;
   assign pop_addr   = SAW'(sp_reg - SPW'(1));
   assign push_addr  = SAW'(sp_reg);
   assign entry_data = is_del_reg ? '0 : {link_reg, rule_reg, 6'b0, dst_reg, 6'b0, src_reg};

   assign bus.cmd_ready  = (state_reg == S_IDLE);
   assign bus.tbl_we     = write_fire;
   assign bus.tbl_index  = write_fire ? idx_reg : '0;
   assign bus.tbl_din    = write_fire ? entry_data : '0;
   assign bus.rsp_valid  = (state_reg == S_RESP);
   assign bus.rsp_index  = err_reg ? '0 : idx_reg;
   assign bus.rsp_err    = err_reg;
   assign bus.free_count = (IW+1)'(sp_reg) + (BUMP_END - bump_reg);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_reg <= S_IDLE;
      else     state_reg <= state_next;
   end

   // Next-state decode.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               if (bus.cmd_op == OP_INSERT)      state_next = S_ALLOC;
               else if (bus.cmd_op == OP_DELETE) state_next = S_WRITE;
               else                              state_next = S_RESP;
            end
         end
         S_ALLOC: state_next = pool_empty ? S_RESP : S_WRITE;
         S_WRITE: state_next = S_RESP;
         S_RESP:  if (bus.rsp_ready) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Command latch, slot allocation and free-pool bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         is_del_reg <= 1'b0;
         err_reg    <= 1'b0;
         idx_reg    <= '0;
         src_reg    <= '0;
         dst_reg    <= '0;
         rule_reg   <= '0;
         link_reg   <= '0;
         bump_reg   <= (IW+1)'(1);
         sp_reg     <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  src_reg    <= bus.cmd_srcIP;
                  dst_reg    <= bus.cmd_dstIP;
                  rule_reg   <= bus.cmd_ruleID;
                  link_reg   <= bus.cmd_link;
                  is_del_reg <= (bus.cmd_op == OP_DELETE);
                  if (bus.cmd_op == OP_INSERT) begin
                     err_reg <= 1'b0;
                     idx_reg <= '0;
                  end else if (bus.cmd_op == OP_DELETE) begin
                     err_reg <= del_bad;
                     idx_reg <= bus.cmd_index;
                  end else begin
                     err_reg <= 1'b1;
                     idx_reg <= '0;
                  end
               end
            end
            S_ALLOC: begin
               if (pool_empty) begin
                  err_reg <= 1'b1;
                  idx_reg <= '0;
               end else if (sp_reg != '0) begin
                  idx_reg <= stack_mem[pop_addr];
                  sp_reg  <= sp_reg - SPW'(1);
               end else begin
                  idx_reg  <= bump_reg[IW-1:0];
                  bump_reg <= bump_reg + (IW+1)'(1);
               end
            end
            S_WRITE: begin
               if (is_del_reg && !err_reg) sp_reg <= sp_reg + SPW'(1);
            end
            default: ;
         endcase
      end
   end

   // Recycled-index stack storage; freed slots are pushed in the delete's WRITE cycle.
   always_ff @(posedge clk) begin
      if (state_reg == S_WRITE && is_del_reg && !err_reg) stack_mem[push_addr] <= idx_reg;
   end
endmodule

// File: tb/tb_smallseg_g0_update_writer.sv
// Scoreboard bench for the G0 update writer: a reference allocator predicts
// each response and write, a negedge monitor compares them as they appear.
`timescale 1ns/1ps
module tb_smallseg_g0_update_writer;
   localparam int TES        = 1738;
   localparam int FREE_DEPTH = 64;
   localparam logic [1:0] OP_NOP = 2'd0, OP_INS = 2'd1, OP_DEL = 2'd2, OP_RSV = 2'd3;

   typedef struct {
      logic [1:0]  op;
      logic        err;
      logic [10:0] idx;
      logic [97:0] din;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   smallseg_g0_update_writer_if bus ();
   smallseg_g0_update_writer dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   logic [1:0]  acc_op = 2'd0;
   logic [10:0] last_rsp_idx = '0;
   logic        last_rsp_err = 1'b0;
   bit          wr_done = 0;
   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [10:0] model_stack[$];
   int          model_bump = 1;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: latency/index/data of every write, fields of every response.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.cmd_valid && bus.cmd_ready) begin
            acc_cyc = cyc;
            acc_op  = bus.cmd_op;
         end
         if (bus.tbl_we) begin
            vectors++;
            if (exp_q.size() == 0 || exp_q[0].err || wr_done) begin
               miscompares++;
               $display("FAIL unexpected_write: tbl_we=1 at index %0d, required no write", bus.tbl_index);
            end else begin
               if (bus.tbl_index !== exp_q[0].idx) begin
                  miscompares++;
                  $display("FAIL write_index: got %0d, required %0d", bus.tbl_index, exp_q[0].idx);
               end
               vectors++;
               if (bus.tbl_din !== exp_q[0].din) begin
                  miscompares++;
                  $display("FAIL write_data: got %h, required %h", bus.tbl_din, exp_q[0].din);
               end
               vectors++;
               if ((cyc - acc_cyc) != ((acc_op == OP_INS) ? 2 : 1)) begin
                  miscompares++;
                  $display("FAIL write_latency: got %0d cycles, required %0d", cyc - acc_cyc, (acc_op == OP_INS) ? 2 : 1);
               end
               wr_done = 1;
            end
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            last_rsp_idx = bus.rsp_index;
            last_rsp_err = bus.rsp_err;
            $display("rsp: index=%0d err=%0b free_count=%0d", bus.rsp_index, bus.rsp_err, bus.free_count);
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_rsp: got index %0d err %0b, required no response", bus.rsp_index, bus.rsp_err);
            end else begin
               mon_e = exp_q.pop_front();
               if (bus.rsp_err !== mon_e.err || bus.rsp_index !== mon_e.idx) begin
                  miscompares++;
                  $display("FAIL rsp_fields: got index %0d err %0b, required index %0d err %0b",
                           bus.rsp_index, bus.rsp_err, mon_e.idx, mon_e.err);
               end
               vectors++;
               if (!mon_e.err && !wr_done) begin
                  miscompares++;
                  $display("FAIL missing_write: got no tbl_we pulse, required one at index %0d", mon_e.idx);
               end
               wr_done = 0;
            end
         end
      end
   end

   // Reference allocator: predicts the outcome of a command and queues it.
   task automatic push_exp(input logic [1:0] op, input logic [31:0] src, input logic [31:0] dst,
                           input logic [10:0] rule, input logic [10:0] link, input logic [10:0] index);
      exp_t e;
      e.op = op; e.err = 1'b1; e.idx = '0; e.din = '0;
      if (op == OP_INS) begin
         if (model_stack.size() > 0) begin
            e.idx = model_stack.pop_back(); e.err = 1'b0;
         end else if (model_bump <= TES) begin
            e.idx = 11'(model_bump); model_bump++; e.err = 1'b0;
         end
         if (!e.err) e.din = {link, rule, 6'b0, dst, 6'b0, src};
      end else if (op == OP_DEL) begin
         if (index != 0 && int'(index) <= TES && model_stack.size() < FREE_DEPTH) begin
            e.err = 1'b0; e.idx = index; model_stack.push_back(index);
         end
      end
      exp_q.push_back(e);
   endtask

   function automatic int model_free();
      return model_stack.size() + (TES + 1 - model_bump);
   endfunction

   task automatic drive_cmd(input logic [1:0] op, input logic [31:0] src, input logic [31:0] dst,
                            input logic [10:0] rule, input logic [10:0] link, input logic [10:0] index);
      int n;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_srcIP = src; bus.cmd_dstIP = dst;
      bus.cmd_ruleID = rule; bus.cmd_link = link; bus.cmd_index = index;
      n = 0;
      @(negedge clk);
      while (!bus.cmd_ready && n < 100) begin @(negedge clk); n++; end
      if (!bus.cmd_ready) begin
         vectors++; miscompares++;
         $display("FAIL accept_timeout: cmd_ready=%0b, required 1", bus.cmd_ready);
      end
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0; bus.cmd_op = OP_NOP;
   endtask

   task automatic wait_done();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
      if (exp_q.size() != 0) begin
         vectors++; miscompares++;
         $display("FAIL rsp_timeout: %0d responses outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [31:0] src, input logic [31:0] dst,
                           input logic [10:0] rule, input logic [10:0] link, input logic [10:0] index);
      push_exp(op, src, dst, rule, link, index);
      drive_cmd(op, src, dst, rule, link, index);
      wait_done();
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete(); model_stack.delete(); model_bump = 1; wr_done = 0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      vectors++;
      if (bus.tbl_we !== 1'b0 || bus.tbl_index !== 11'd0 || bus.tbl_din !== 98'd0) begin
         miscompares++;
         $display("FAIL reset_tbl: got we=%0b idx=%0d din=%h, required all zero", bus.tbl_we, bus.tbl_index, bus.tbl_din);
      end
      vectors++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_index !== 11'd0 || bus.rsp_err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_rsp: got valid=%0b idx=%0d err=%0b, required all zero", bus.rsp_valid, bus.rsp_index, bus.rsp_err);
      end
      vectors++;
      if (bus.free_count !== 12'd1738 || bus.cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_pool: got free_count=%0d cmd_ready=%0b, required 1738 and 1", bus.free_count, bus.cmd_ready);
      end
   endtask

   task automatic test_insert_basic();
      do_reset();
      send_cmd(OP_INS, 32'h0A000001, 32'hC0A80001, 11'd5, 11'd0, 11'd0);
      @(negedge clk);
      vectors++;
      if (last_rsp_idx !== 11'd1 || last_rsp_err !== 1'b0 || bus.free_count !== 12'd1737) begin
         miscompares++;
         $display("FAIL insert_basic: got idx=%0d err=%0b free=%0d, required 1 0 1737", last_rsp_idx, last_rsp_err, bus.free_count);
      end
   endtask

   task automatic test_reuse();
      do_reset();
      for (int i = 1; i <= 3; i++) send_cmd(OP_INS, 32'(i), 32'(i * 7), 11'(i), 11'(i + 1), 11'd0);
      send_cmd(OP_DEL, 32'd0, 32'd0, 11'd0, 11'd0, 11'd2);
      vectors++;
      if (last_rsp_idx !== 11'd2 || last_rsp_err !== 1'b0) begin
         miscompares++;
         $display("FAIL delete_rsp: got idx=%0d err=%0b, required 2 0", last_rsp_idx, last_rsp_err);
      end
      send_cmd(OP_INS, 32'h11112222, 32'h33334444, 11'd9, 11'd3, 11'd0);
      vectors++;
      if (last_rsp_idx !== 11'd2) begin
         miscompares++;
         $display("FAIL reuse_stack: got idx=%0d, required 2", last_rsp_idx);
      end
      send_cmd(OP_INS, 32'h55556666, 32'h77778888, 11'd10, 11'd0, 11'd0);
      @(negedge clk);
      vectors++;
      if (last_rsp_idx !== 11'd4 || bus.free_count !== 12'(model_free())) begin
         miscompares++;
         $display("FAIL reuse_bump: got idx=%0d free=%0d, required 4 %0d", last_rsp_idx, bus.free_count, model_free());
      end
   endtask

   task automatic test_delete_err();
      logic [11:0] fc_before;
      logic [10:0] bad_idx [2];
      bad_idx[0] = 11'd0; bad_idx[1] = 11'd1739;
      @(negedge clk);
      fc_before = 12'(model_free());
      for (int i = 0; i < 2; i++) begin
         send_cmd(OP_DEL, 32'd0, 32'd0, 11'd0, 11'd0, bad_idx[i]);
         @(negedge clk);
         vectors++;
         if (last_rsp_err !== 1'b1 || bus.free_count !== fc_before) begin
            miscompares++;
            $display("FAIL delete_bad_%0d: got err=%0b free=%0d, required 1 %0d", bad_idx[i], last_rsp_err, bus.free_count, fc_before);
         end
      end
      send_cmd(OP_NOP, 32'd1, 32'd2, 11'd3, 11'd4, 11'd5);
      send_cmd(OP_RSV, 32'd1, 32'd2, 11'd3, 11'd4, 11'd5);
      @(negedge clk);
      vectors++;
      if (last_rsp_err !== 1'b1 || bus.free_count !== fc_before) begin
         miscompares++;
         $display("FAIL op_reserved: got err=%0b free=%0d, required 1 %0d", last_rsp_err, bus.free_count, fc_before);
      end
   endtask

   task automatic test_backpressure();
      int n;
      do_reset();
      bus.rsp_ready = 1'b0;
      push_exp(OP_INS, 32'hA, 32'hB, 11'd1, 11'd0, 11'd0);
      drive_cmd(OP_INS, 32'hA, 32'hB, 11'd1, 11'd0, 11'd0);
      push_exp(OP_INS, 32'hC, 32'hD, 11'd2, 11'd1, 11'd0);
      bus.cmd_valid = 1'b1; bus.cmd_op = OP_INS; bus.cmd_srcIP = 32'hC; bus.cmd_dstIP = 32'hD;
      bus.cmd_ruleID = 11'd2; bus.cmd_link = 11'd1;
      n = 0;
      @(negedge clk);
      while (!bus.rsp_valid && n < 20) begin @(negedge clk); n++; end
      for (int i = 0; i < 10; i++) begin
         vectors++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_index !== 11'd1 || bus.rsp_err !== 1'b0 || bus.cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_rsp_%0d: got valid=%0b idx=%0d err=%0b ready=%0b, required 1 1 0 0",
                     i, bus.rsp_valid, bus.rsp_index, bus.rsp_err, bus.cmd_ready);
         end
         @(negedge clk);
      end
      @(posedge clk); #1 bus.rsp_ready = 1'b1;
      drive_cmd(OP_INS, 32'hC, 32'hD, 11'd2, 11'd1, 11'd0);
      wait_done();
      vectors++;
      if (last_rsp_idx !== 11'd2) begin
         miscompares++;
         $display("FAIL backpressure_second: got idx=%0d, required 2", last_rsp_idx);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      @(posedge clk); #1;
      bus.cmd_valid = 1'b1; bus.cmd_op = OP_INS; bus.cmd_srcIP = 32'h1; bus.cmd_dstIP = 32'h2;
      bus.cmd_ruleID = 11'd3; bus.cmd_link = 11'd0;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0; bus.cmd_op = OP_NOP;
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      exp_q.delete(); model_stack.delete(); model_bump = 1; wr_done = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         vectors++;
         if (bus.tbl_we !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.free_count !== 12'd1738) begin
            miscompares++;
            $display("FAIL reset_abort_%0d: got we=%0b rsp_valid=%0b free=%0d, required 0 0 1738",
                     i, bus.tbl_we, bus.rsp_valid, bus.free_count);
         end
      end
      send_cmd(OP_INS, 32'h1, 32'h2, 11'd3, 11'd0, 11'd0);
      vectors++;
      if (last_rsp_idx !== 11'd1) begin
         miscompares++;
         $display("FAIL reset_next_insert: got idx=%0d, required 1", last_rsp_idx);
      end
   endtask

   task automatic test_exhaust();
      do_reset();
      for (int i = 1; i <= TES; i++) send_cmd(OP_INS, 32'(i), ~32'(i), 11'(i), 11'(i + 1), 11'd0);
      @(negedge clk);
      vectors++;
      if (last_rsp_idx !== 11'd1738 || bus.free_count !== 12'd0) begin
         miscompares++;
         $display("FAIL fill_all: got idx=%0d free=%0d, required 1738 0", last_rsp_idx, bus.free_count);
      end
      send_cmd(OP_INS, 32'hDEAD, 32'hBEEF, 11'd1, 11'd0, 11'd0);
      @(negedge clk);
      vectors++;
      if (last_rsp_err !== 1'b1 || last_rsp_idx !== 11'd0 || bus.free_count !== 12'd0) begin
         miscompares++;
         $display("FAIL pool_empty: got err=%0b idx=%0d free=%0d, required 1 0 0", last_rsp_err, last_rsp_idx, bus.free_count);
      end
      send_cmd(OP_DEL, 32'd0, 32'd0, 11'd0, 11'd0, 11'd100);
      send_cmd(OP_INS, 32'h100, 32'h200, 11'd7, 11'd0, 11'd0);
      vectors++;
      if (last_rsp_idx !== 11'd100) begin
         miscompares++;
         $display("FAIL refill_100: got idx=%0d, required 100", last_rsp_idx);
      end
      for (int i = 1; i <= FREE_DEPTH; i++) send_cmd(OP_DEL, 32'd0, 32'd0, 11'd0, 11'd0, 11'(i));
      send_cmd(OP_DEL, 32'd0, 32'd0, 11'd0, 11'd0, 11'd65);
      @(negedge clk);
      vectors++;
      if (last_rsp_err !== 1'b1 || bus.free_count !== 12'd64) begin
         miscompares++;
         $display("FAIL stack_full: got err=%0b free=%0d, required 1 64", last_rsp_err, bus.free_count);
      end
      send_cmd(OP_INS, 32'h5, 32'h6, 11'd8, 11'd0, 11'd0);
      vectors++;
      if (last_rsp_idx !== 11'd64) begin
         miscompares++;
         $display("FAIL lifo_order: got idx=%0d, required 64", last_rsp_idx);
      end
   endtask

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_op = OP_NOP; bus.cmd_srcIP = '0; bus.cmd_dstIP = '0;
      bus.cmd_ruleID = '0; bus.cmd_link = '0; bus.cmd_index = '0; bus.rsp_ready = 1'b1;
      test_reset();
      test_insert_basic();
      test_reuse();
      test_delete_err();
      test_backpressure();
      test_reset_mid();
      test_exhaust();
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end
endmodule
